// File: rtl/read_iq_pkg.sv
// Shared definitions for the read_iq byte-to-I/Q unpacker: parameter defaults,
// FSM state type and the sign-extend/scale helper.
package read_iq_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int BITS_DEF       = 10;

  // Widest sample the helper can produce; the unpacker truncates to DATA_WIDTH.
  localparam int MAX_WIDTH = 64;

  typedef enum logic {
    S_READ  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  // Sign-extend a 16-bit sample, then multiply by 2^shift (low bits kept).
  function automatic logic [MAX_WIDTH-1:0] dequantize(input logic [15:0]   sample,
                                                      input int unsigned   shift);
    logic [MAX_WIDTH-1:0] ext;
    ext = {{(MAX_WIDTH-16){sample[15]}}, sample};
    return ext << shift;
  endfunction

endpackage

// File: rtl/read_iq.sv
// Unpacks little-endian byte quads (I lo, I hi, Q lo, Q hi) from a FWFT FIFO into
// paired I/Q sample writes. Define IQ_DEQUANT_EN to scale each sample by 2^BITS.
module read_iq
  import read_iq_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BITS       = BITS_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  in_rd_en,
  input  logic                  in_empty,
  input  logic [7:0]            in_dout,
  output logic                  i_wr_en,
  input  logic                  i_full,
  output logic [DATA_WIDTH-1:0] i_din,
  output logic                  q_wr_en,
  input  logic                  q_full,
  output logic [DATA_WIDTH-1:0] q_din
);

`ifdef IQ_DEQUANT_EN
  localparam bit DEQUANT = 1'b1;
`else
  localparam bit DEQUANT = 1'b0;
`endif
  localparam int unsigned SHIFT = DEQUANT ? BITS : 0;

  state_t      state, next_state;
  logic [1:0]  byte_cnt;
  logic [15:0] i_word;
  logic [7:0]  q_lo;
  logic        consume;

  // Reset gates the pop strobe so nothing is taken from the FIFO while held.
  assign consume = reset && (state == S_READ) && !in_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_READ;
    else        state <= next_state;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    in_rd_en   = 1'b0;
    i_wr_en    = 1'b0;
    q_wr_en    = 1'b0;
    unique case (state)
      S_READ: begin
        in_rd_en = consume;
        if (consume && byte_cnt == 2'd3) next_state = S_WRITE;
      end
      S_WRITE: begin
        // Both FIFOs must have room: I and Q are only ever written together.
        if (!i_full && !q_full) begin
          i_wr_en    = 1'b1;
          q_wr_en    = 1'b1;
          next_state = S_READ;
        end
      end
      default: next_state = S_READ;
    endcase
  end

  // NOTE: the partial word and sample registers are reset so a word interrupted
  // by reset can never leak into a later pair.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_cnt <= 2'd0;
      i_word   <= '0;
      q_lo     <= '0;
      i_din    <= '0;
      q_din    <= '0;
    end else if (consume) begin
      byte_cnt <= byte_cnt + 2'd1;
      unique case (byte_cnt)
        2'd0: i_word[7:0]  <= in_dout;
        2'd1: i_word[15:8] <= in_dout;
        2'd2: q_lo         <= in_dout;
        2'd3: begin
          // Final byte completes Q; both samples are registered together.
          i_din <= DATA_WIDTH'(dequantize(i_word, SHIFT));
          q_din <= DATA_WIDTH'(dequantize({in_dout, q_lo}, SHIFT));
        end
      endcase
    end
  end

endmodule

// File: tb/tb_read_iq.sv
// Self-checking bench for read_iq: byte-FIFO model, scoreboard of expected pairs,
// table vectors, backpressure/stall/reset sequences and a randomized run.
module tb_read_iq;

  localparam int DATA_WIDTH = 32;
  localparam int BITS       = 10;
`ifdef IQ_DEQUANT_EN
  localparam int SCALE_SHIFT = BITS;
  localparam logic [31:0] EXP0_I = 32'd1024;
  localparam logic [31:0] EXP0_Q = 32'hFFFF_FC00;
  localparam logic [31:0] EXP1_I = 32'hFE00_0000;
  localparam logic [31:0] EXP1_Q = 32'h01FF_FC00;
`else
  localparam int SCALE_SHIFT = 0;
  localparam logic [31:0] EXP0_I = 32'd1;
  localparam logic [31:0] EXP0_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP1_I = 32'hFFFF_8000;
  localparam logic [31:0] EXP1_Q = 32'h0000_7FFF;
`endif

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  in_rd_en;
  logic                  in_empty;
  logic [7:0]            in_dout;
  logic                  i_wr_en;
  logic                  i_full;
  logic [DATA_WIDTH-1:0] i_din;
  logic                  q_wr_en;
  logic                  q_full;
  logic [DATA_WIDTH-1:0] q_din;

  read_iq #(.DATA_WIDTH(DATA_WIDTH), .BITS(BITS)) dut (
    .clock(clock), .reset(reset),
    .in_rd_en(in_rd_en), .in_empty(in_empty), .in_dout(in_dout),
    .i_wr_en(i_wr_en), .i_full(i_full), .i_din(i_din),
    .q_wr_en(q_wr_en), .q_full(q_full), .q_din(q_din)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] i;
    logic [31:0] q;
  } pair_t;

  typedef struct {
    logic [3:0][7:0] b;      // b[0] is the first byte on the wire
    int              raw_i;
    int              raw_q;
  } vec_t;

  logic [7:0] src_q[$];
  pair_t      exp_q[$];
  int         wr_cycle[$];
  int         rd_cycle[$];
  pair_t      last_pair;
  bit         stall, i_full_req, q_full_req;
  logic       pop;
  int         cycle;
  int         checks, errors;
  vec_t       tbl[6];

  function automatic logic [31:0] scale(input int raw);
    longint v;
    v = longint'(raw) * (longint'(1) << SCALE_SHIFT);
    return v[31:0];
  endfunction

  function automatic int to_signed16(input logic [7:0] lo, input logic [7:0] hi);
    int v;
    v = int'(hi) * 256 + int'(lo);
    if (v >= 32768) v -= 65536;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at cycle %0d",
               name, $signed(act), act, $signed(exp), exp, cycle);
    end
  endtask

  task automatic push_bytes(input logic [3:0][7:0] b, input int n);
    for (int k = 0; k < n; k++) src_q.push_back(b[k]);
  endtask

  task automatic push_vec(input vec_t v);
    pair_t p;
    push_bytes(v.b, 4);
    p.i = scale(v.raw_i);
    p.q = scale(v.raw_q);
    exp_q.push_back(p);
  endtask

  task automatic push_random_word();
    vec_t v;
    for (int k = 0; k < 4; k++) v.b[k] = 8'($urandom);
    v.raw_i = to_signed16(v.b[0], v.b[1]);
    v.raw_q = to_signed16(v.b[2], v.b[3]);
    push_vec(v);
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0) && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0 || src_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d pairs pending, %0d bytes unconsumed after %0d cycles",
               name, exp_q.size(), src_q.size(), n);
    end
  endtask

  task automatic wait_src_empty(input string name, input int max_cycles);
    int n = 0;
    while (src_q.size() != 0 && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (src_q.size() != 0) begin
      errors++;
      $display("FAIL src_empty_%s: %0d bytes unconsumed after %0d cycles", name, src_q.size(), n);
    end
  endtask

  // Upstream FWFT FIFO model: pops on in_rd_en at the edge, junk data while empty.
  always @(posedge clock) begin
    pop = in_rd_en;
    cycle++;
    #1;
    if (pop && src_q.size() > 0) void'(src_q.pop_front());
    in_empty = stall || (src_q.size() == 0);
    in_dout  = in_empty ? 8'($urandom) : src_q[0];
    i_full   = i_full_req;
    q_full   = q_full_req;
  end

  // Protocol invariants and scoreboard, sampled mid-cycle.
  always @(negedge clock) begin
    check("rd_while_empty", 32'(in_rd_en & in_empty), 32'd0);
    check("wr_en_paired", 32'(i_wr_en), 32'(q_wr_en));
    check("rd_during_write", 32'(in_rd_en & (i_wr_en | q_wr_en)), 32'd0);
    check("wr_while_full", 32'((i_wr_en | q_wr_en) & (i_full | q_full)), 32'd0);
    if (in_rd_en) rd_cycle.push_back(cycle);
    if (i_wr_en && q_wr_en) begin
      pair_t p;
      wr_cycle.push_back(cycle);
      last_pair.i = i_din;
      last_pair.q = q_din;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: i=%0d q=%0d at cycle %0d", $signed(i_din), $signed(q_din), cycle);
      end else begin
        p = exp_q.pop_front();
        check("i_din", i_din, p.i);
        check("q_din", q_din, p.q);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    pair_t held;
    checks = 0; errors = 0; cycle = 0;
    stall = 0; i_full_req = 0; q_full_req = 0;
    reset = 1'b0; in_empty = 1'b1; in_dout = 8'h00; i_full = 1'b0; q_full = 1'b0;

    tbl[0] = '{b: {8'hFF, 8'hFF, 8'h00, 8'h01}, raw_i: 1,      raw_q: -1};
    tbl[1] = '{b: {8'h7F, 8'hFF, 8'h80, 8'h00}, raw_i: -32768, raw_q: 32767};
    tbl[2] = '{b: {8'h00, 8'h06, 8'h00, 8'h05}, raw_i: 5,      raw_q: 6};
    tbl[3] = '{b: {8'h80, 8'h00, 8'h7F, 8'hFF}, raw_i: 32767,  raw_q: -32768};
    tbl[4] = '{b: {8'hAB, 8'hCD, 8'h12, 8'h34}, raw_i: 4660,   raw_q: -21555};
    tbl[5] = '{b: {8'h00, 8'h00, 8'h00, 8'h00}, raw_i: 0,      raw_q: 0};

    // Reset state, with data already waiting upstream.
    push_vec(tbl[0]);
    repeat (3) @(negedge clock);
    check("rst_in_rd_en", 32'(in_rd_en), 32'd0);
    check("rst_i_wr_en", 32'(i_wr_en), 32'd0);
    check("rst_q_wr_en", 32'(q_wr_en), 32'd0);
    check("rst_i_din", i_din, 32'd0);
    check("rst_q_din", q_din, 32'd0);
    #2 reset = 1'b1;

    // Table vectors, one word at a time.
    for (int v = 0; v < 6; v++) begin
      if (v != 0) push_vec(tbl[v]);
      wait_drain("table", 50);
      check("tbl_i", last_pair.i, scale(tbl[v].raw_i));
      check("tbl_q", last_pair.q, scale(tbl[v].raw_q));
      if (v == 0) begin
        check("lit01_i", last_pair.i, EXP0_I);
        check("lit01_q", last_pair.q, EXP0_Q);
      end
      if (v == 1) begin
        check("lit80_i", last_pair.i, EXP1_I);
        check("lit80_q", last_pair.q, EXP1_Q);
      end
    end

    // Unthrottled burst: latency of one cycle after byte 3, one pair per 5 cycles.
    wr_cycle.delete(); rd_cycle.delete();
    for (int w = 0; w < 4; w++) push_vec(tbl[(w + 1) % 6]);
    wait_drain("burst", 100);
    check("burst_reads", 32'(rd_cycle.size()), 32'd16);
    check("burst_writes", 32'(wr_cycle.size()), 32'd4);
    if (rd_cycle.size() >= 4 && wr_cycle.size() >= 4) begin
      check("latency", 32'(wr_cycle[0] - rd_cycle[3]), 32'd1);
      check("throughput", 32'(wr_cycle[3] - wr_cycle[0]), 32'd15);
    end

    // Backpressure on Q for 10 cycles with more bytes waiting upstream.
    q_full_req = 1;
    push_vec(tbl[4]);
    held.i = scale(tbl[4].raw_i);
    held.q = scale(tbl[4].raw_q);
    wait_src_empty("bp", 50);
    wr_cycle.delete();
    push_vec(tbl[2]);
    repeat (10) begin
      @(negedge clock);
      check("bp_rd_en", 32'(in_rd_en), 32'd0);
      check("bp_wr_en", 32'(i_wr_en | q_wr_en), 32'd0);
      check("bp_i_hold", i_din, held.i);
      check("bp_q_hold", q_din, held.q);
    end
    q_full_req = 0;
    @(negedge clock);
    check("bp_release_wr", 32'(i_wr_en & q_wr_en), 32'd1);
    check("bp_release_i", i_din, held.i);
    wait_drain("bp", 50);
    check("bp_writes", 32'(wr_cycle.size()), 32'd2);

    // Upstream empty between every byte: two pairs, nothing lost or doubled.
    wr_cycle.delete(); rd_cycle.delete();
    push_vec(tbl[3]);
    push_vec(tbl[4]);
    for (int n = 0; n < 200 && (exp_q.size() != 0 || src_q.size() != 0); n++) begin
      @(negedge clock);
      stall = ~stall;
    end
    stall = 0;
    wait_drain("stall", 50);
    check("stall_reads", 32'(rd_cycle.size()), 32'd8);
    check("stall_writes", 32'(wr_cycle.size()), 32'd2);

    // Reset mid-word: two bytes discarded, the next byte is byte 0 again.
    push_bytes({8'h00, 8'h00, 8'h22, 8'h11}, 2);
    wait_src_empty("partial", 50);
    @(negedge clock);
    #2 reset = 1'b0;
    push_vec(tbl[2]);
    repeat (3) begin
      @(negedge clock);
      check("rst2_rd_en", 32'(in_rd_en), 32'd0);
      check("rst2_wr_en", 32'(i_wr_en | q_wr_en), 32'd0);
    end
    #2 reset = 1'b1;
    wait_drain("partial", 50);
    check("rst2_i", last_pair.i, scale(5));
    check("rst2_q", last_pair.q, scale(6));

    // Reset while a pair is held by backpressure: the pair is dropped, asynchronously.
    i_full_req = 1;
    push_vec(tbl[1]);
    wait_src_empty("pending", 50);
    @(negedge clock);
    #2 reset = 1'b0;
    exp_q.delete();
    #1;
    check("async_i_din", i_din, 32'd0);
    check("async_q_din", q_din, 32'd0);
    i_full_req = 0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    wr_cycle.delete();
    push_vec(tbl[0]);
    wait_drain("pending", 50);
    check("pending_writes", 32'(wr_cycle.size()), 32'd1);

    // Randomized traffic with random stalls and full flags.
    for (int w = 0; w < 30; w++) push_random_word();
    for (int n = 0; n < 3000 && (exp_q.size() != 0 || src_q.size() != 0); n++) begin
      @(negedge clock);
      stall      = ($urandom_range(3) == 0);
      i_full_req = ($urandom_range(4) == 0);
      q_full_req = ($urandom_range(4) == 0);
    end
    stall = 0; i_full_req = 0; q_full_req = 0;
    wait_drain("random", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_iq.md
READ_IQ -- requirements
Module: read_iq

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of each output sample.
REQ-002 Parameter BITS, default 10, SHALL set the dequantization shift amount.
REQ-003 Port clock, input, 1, SHALL be the single rising-edge clock for all state.
REQ-004 Port reset, input, 1, SHALL be the asynchronous, active-low reset.
REQ-005 Port in_rd_en, output, 1, SHALL be the pop strobe to the upstream first-word-fall-through byte FIFO.
REQ-006 Port in_empty, input, 1, SHALL indicate that the upstream FIFO is empty.
REQ-007 Port in_dout, input, 8, SHALL carry the upstream byte, valid whenever in_empty=0.
REQ-008 Port i_wr_en, output, 1, SHALL be the write strobe to the I sample FIFO.
REQ-009 Port i_full, input, 1, SHALL indicate that the I FIFO is full.
REQ-010 Port i_din, output, DATA_WIDTH, SHALL carry the signed I sample.
REQ-011 Port q_wr_en, output, 1, SHALL be the write strobe to the Q sample FIFO.
REQ-012 Port q_full, input, 1, SHALL indicate that the Q FIFO is full.
REQ-013 Port q_din, output, DATA_WIDTH, SHALL carry the signed Q sample.

Function
REQ-014 The FSM SHALL have exactly two states: S_READ (collecting bytes) and S_WRITE (emitting one sample pair).
REQ-015 In S_READ, in_rd_en SHALL equal !in_empty, combinationally; each cycle with in_rd_en=1 SHALL consume one byte.
REQ-016 A 2-bit byte counter SHALL place consumed bytes as: 0 -> I[7:0], 1 -> I[15:8], 2 -> Q[7:0], 3 -> Q[15:8] (little-endian, I first).
REQ-017 Consuming byte 3 SHALL wrap the counter to 0 and move the FSM to S_WRITE on the next edge.
REQ-018 In S_READ, a cycle with in_empty=1 SHALL hold the counter and the partial word unchanged (stall, no data loss).
REQ-019 In S_WRITE, in_rd_en SHALL be 0.
REQ-020 In S_WRITE with i_full=0 and q_full=0, i_wr_en and q_wr_en SHALL both be 1 for exactly one cycle, and the FSM SHALL return to S_READ.
REQ-021 In S_WRITE with either full flag high, both wr_en outputs SHALL be 0; the FSM SHALL stay in S_WRITE and the held sample SHALL remain on i_din/q_din.
REQ-022 I and Q SHALL always be written in the same cycle; a write to one FIFO alone is forbidden.
REQ-023 Each 16-bit half SHALL be sign-extended to DATA_WIDTH before any scaling.
REQ-024 Latency SHALL be 1 cycle from consumption of byte 3 to the wr_en pulse when not backpressured.
REQ-025 Unthrottled throughput SHALL be one I/Q pair per 5 cycles.
REQ-026 i_din and q_din SHALL be driven from registers; wr_en outputs MAY be combinational from state and full flags.

Reset
REQ-027 While reset=0: FSM = S_READ, byte counter = 0, sample registers = 0, and in_rd_en, i_wr_en, q_wr_en = 0.
REQ-028 Reset asserted mid-word or in S_WRITE SHALL discard the partial or pending pair; after release, the next consumed byte SHALL be treated as byte 0.

Configuration
REQ-029 With IQ_DEQUANT_EN defined, each output SHALL be the sign-extended sample shifted left by BITS, keeping the low DATA_WIDTH bits (arithmetic multiply by 2^BITS).
REQ-030 With IQ_DEQUANT_EN undefined, each output SHALL be the plain sign-extended sample; the BITS parameter is then unused.

Structure
REQ-031 A shared package SHALL hold the DATA_WIDTH and BITS defaults, the state enum typedef, and a DEQUANTIZE function (sign-extend plus shift).
REQ-032 The block SHALL be a single module with no sub-module; the FIFOs SHALL be instantiated by the parent.

Verification
REQ-033 Bytes 01 00 FF FF with IQ_DEQUANT_EN defined -> one pair written: I=1024, Q=-1024.
REQ-034 Same bytes with IQ_DEQUANT_EN undefined -> I=1, Q=-1.
REQ-035 Bytes 00 80 FF 7F with IQ_DEQUANT_EN defined -> I=-33554432, Q=33553408.
REQ-036 q_full held high for 10 cycles after byte 3 -> no writes and in_rd_en=0 throughout; the pair is written in the cycle q_full drops, with values unchanged.
REQ-037 in_empty pulsed high between every byte of 8 bytes -> exactly 2 correctly ordered pairs written, no lost or duplicated bytes.
REQ-038 Reset asserted after 2 bytes, then bytes 05 00 06 00 applied -> the single pair written is I=5<<BITS, Q=6<<BITS (macro on).
